// File: rtl/dcache_mem_stage.sv
// dcache_mem_stage
//   Direct-mapped, write-through, read-allocate data cache that sits in the
//   memory stage between the EX/MEM and MEM/WB registers. Loads that hit are
//   served combinationally. Load misses refill a whole line one word at a
//   time over a req/ack backing-memory port. Every store is forwarded to
//   backing memory, and a store that hits also updates the cached copy.
//   While the cache is busy it raises stall to freeze the front of the pipe.
//
// Ports
//   clock, rst        rising-edge clock, asynchronous active-low reset
//   memRead/memWrite  load / store request from EX/MEM (write wins if both)
//   word              1 = 32-bit access, 0 = byte access (sign-extended loads)
//   address           byte address; writeData store data (bytes use [7:0])
//   readData          load data to MEM/WB (holds when no load is presented)
//   stall             pipeline freeze request
//   mem_req/mem_we    backing request and direction (1 = write)
//   mem_addr          word-aligned backing address
//   mem_wdata/mem_be  backing write data and byte enables
//   mem_rdata/mem_ack backing read data, one-cycle acknowledge per word
//
// Optional feature (macro DCACHE_STATS_EN)
//   Adds saturating hit_count / miss_count outputs.

module dcache_mem_stage #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        word,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 32 - 2 - WB - IB;
  localparam int SB = IB + WB;

  typedef enum logic [1:0] {IDLE, REFILL, WTHRU} state_t;

  state_t               state;
  logic [WB-1:0]        beat;
  logic [WB-1:0]        beat_next;
  logic                 redo;
  logic [NUM_LINES-1:0] valid;
  logic [TB-1:0]        tags  [NUM_LINES];
  logic [31:0]          lines [NUM_LINES*LINE_WORDS];
  logic [31:0]          read_hold;

  logic [WB-1:0] acc_word;
  logic [IB-1:0] acc_index;
  logic [TB-1:0] acc_tag;
  logic [SB-1:0] acc_slot;
  logic [SB-1:0] fill_slot;
  logic          hit;
  logic          idle;
  logic          do_read;
  logic          read_hit;
  logic          start_refill;
  logic          start_write;
  logic          last_beat;
  logic [31:0]   cached;
  logic [31:0]   load_val;
  logic [31:0]   wr_data;
  logic [31:0]   merged;
  logic [7:0]    cached_byte;
  logic [3:0]    wr_be;

  assign acc_word  = address[2 +: WB];
  assign acc_index = address[2+WB +: IB];
  assign acc_tag   = address[31 -: TB];
  assign acc_slot  = {acc_index, acc_word};
  assign fill_slot = {acc_index, beat};
  assign beat_next = beat + WB'(1);
  assign last_beat = (beat == WB'(LINE_WORDS - 1));

  assign hit         = valid[acc_index] && (tags[acc_index] == acc_tag);
  assign cached      = lines[acc_slot];
  assign cached_byte = cached[{address[1:0], 3'b000} +: 8];
  assign load_val    = word ? cached : {{24{cached_byte[7]}}, cached_byte};

  // Byte stores replicate the byte on every lane so the enables alone select it.
  assign wr_be   = word ? 4'b1111 : (4'b0001 << address[1:0]);
  assign wr_data = word ? writeData : {4{writeData[7:0]}};

  // redo marks the IDLE cycle right after a refill or write-through finishes.
  // EX/MEM still holds the same instruction then, so a store seen with redo
  // set has already been sent and simply completes with stall low.
  assign idle         = (state == IDLE);
  assign do_read      = memRead && !memWrite;
  assign read_hit     = idle && do_read && hit;
  assign start_refill = idle && do_read && !hit;
  assign start_write  = idle && memWrite && !redo;

  assign stall    = rst && (!idle || start_refill || start_write);
  assign readData = read_hit ? load_val : read_hold;

  // Merge the store bytes into the currently cached word for a write hit.
  always_comb begin
    merged = cached;
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // Line and tag storage. There is no reset here because the valid bits
  // alone decide whether this storage holds anything meaningful.
  always_ff @(posedge clock) begin
    if (state == REFILL && mem_ack) begin
      lines[fill_slot] <= mem_rdata;
      if (last_beat) tags[acc_index] <= acc_tag;
    end else if (start_write && hit) begin
      lines[acc_slot] <= merged;
    end
  end

  // Control FSM with registered backing-memory outputs. Request fields are
  // loaded when a transaction starts and stay stable until its ack. The
  // valid bit is set only on the final refill ack, so a reset mid-refill
  // leaves the line invalid.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      redo      <= 1'b0;
      valid     <= '0;
      read_hold <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          redo <= 1'b0;
          if (read_hit) read_hold <= load_val;
          if (start_write) begin
            state     <= WTHRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {address[31:2], 2'b00};
            mem_wdata <= wr_data;
            mem_be    <= wr_be;
          end else if (start_refill) begin
            state    <= REFILL;
            beat     <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {address[31:2+WB], {WB{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (last_beat) begin
              state            <= IDLE;
              valid[acc_index] <= 1'b1;
              redo             <= 1'b1;
              mem_req          <= 1'b0;
              mem_addr         <= '0;
            end else begin
              beat     <= beat_next;
              mem_addr <= {address[31:2+WB], beat_next, 2'b00};
            end
          end
        end
        WTHRU: begin
          if (mem_ack) begin
            state     <= IDLE;
            redo      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Hits are counted on first evaluation only; the re-evaluation after a
  // refill (redo set) is part of the miss already counted.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (((read_hit && !redo) || (start_write && hit)) && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if ((start_refill || (start_write && !hit)) && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// tb_dcache_mem_stage
//   Directed scoreboard bench for dcache_mem_stage. Stimulus pushes the
//   expected backing-memory transactions and access completions into queues.
//   A monitor pops and compares them whenever the DUT shows a transaction
//   (mem_req && mem_ack) or completes an access (request with stall low).
//   A small responder acts as backing memory and acks immediately.

module tb_dcache_mem_stage;

  logic        clock;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic        word;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_txn_t;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          stalls;
  } acc_t;

  mem_txn_t    mem_q[$];
  acc_t        acc_q[$];
  mem_txn_t    exp_txn;
  acc_t        exp_acc;
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] wr_merge;
  int          checks    = 0;
  int          errors    = 0;
  int          stall_cnt = 0;

  dcache_mem_stage dut (
    .clock     (clock),
    .rst       (rst),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .word      (word),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  task automatic pushRefill(input logic [31:0] base);
    for (int w = 0; w < 4; w++) mem_q.push_back('{1'b0, base + 32'(w * 4), 32'h0, 4'h0});
  endtask

  task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    mem_q.push_back('{1'b1, addr, data, be});
  endtask

  task automatic pushAcc(input logic is_read, input logic [31:0] data, input int stalls);
    acc_q.push_back('{is_read, data, stalls});
  endtask

  // Present one access and hold it until the cycle where stall is low.
  task automatic applyStimulus(input logic rd, input logic wr, input logic wd,
                               input logic [31:0] addr, input logic [31:0] data);
    int n;
    memRead   = rd;
    memWrite  = wr;
    word      = wd;
    address   = addr;
    writeData = data;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (stall && n < 40);
    if (stall) checkOutput("access_timeout_stall", 32'(stall), 32'h0);
    @(posedge clock);
    #2;
  endtask

  // Backing memory: acks every cycle a request is up, one word per ack.
  always @(posedge clock) begin
    #1;
    if (rst && mem_req) begin
      mem_ack   = 1'b1;
      mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : 32'h0;
      if (mem_we) begin
        wr_merge = mem_rdata;
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) wr_merge[8*b +: 8] = mem_wdata[8*b +: 8];
        bmem[mem_addr] = wr_merge;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  // Monitor: compares backing transactions and access completions.
  always @(negedge clock) begin
    if (!rst) begin
      stall_cnt = 0;
    end else begin
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL mem_txn_unexpected actual addr=0x%08h we=%0b required no request",
                   mem_addr, mem_we);
        end else begin
          exp_txn = mem_q.pop_front();
          checkOutput("mem_we", 32'(mem_we), 32'(exp_txn.we));
          checkOutput("mem_addr", mem_addr, exp_txn.addr);
          if (exp_txn.we) begin
            checkOutput("mem_wdata", mem_wdata, exp_txn.wdata);
            checkOutput("mem_be", 32'(mem_be), 32'(exp_txn.be));
          end
        end
      end
      if (memRead || memWrite) begin
        if (stall) begin
          stall_cnt++;
        end else begin
          if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL access_unexpected actual addr=0x%08h required no completion", address);
          end else begin
            exp_acc = acc_q.pop_front();
            checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_acc.stalls));
            if (exp_acc.is_read) checkOutput("readData", readData, exp_acc.data);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin
    int n;
    int acks;
    rst       = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    word      = 1'b0;
    address   = 32'h0;
    writeData = 32'h0;

    bmem[32'h100] = 32'h11;  bmem[32'h104] = 32'h22;
    bmem[32'h108] = 32'h33;  bmem[32'h10C] = 32'h44;
    bmem[32'h200] = 32'h55;  bmem[32'h204] = 32'h66;
    bmem[32'h208] = 32'h77;  bmem[32'h20C] = 32'h88;
    bmem[32'h304] = 32'hA1;  bmem[32'h308] = 32'hA2;
    bmem[32'h30C] = 32'h7F123456;
    bmem[32'h400] = 32'hB0;  bmem[32'h404] = 32'hB1;
    bmem[32'h408] = 32'hB2;  bmem[32'h40C] = 32'hB3;

    repeat (2) @(posedge clock);
    #2;
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset_mem_be", 32'(mem_be), 32'h0);
    checkOutput("reset_readData", readData, 32'h0);
    rst = 1'b1;
    $display("[TB] reset released, starting directed accesses");

    // Cold load: four refill beats, five stall cycles, then hit.
    pushRefill(32'h100);
    pushAcc(1'b1, 32'h11, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);

    // Back-to-back hit on the same line.
    pushAcc(1'b1, 32'h33, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h108, 32'h0);

    // Byte store hit, then byte and word loads see the merged data.
    pushWrite(32'h100, 32'h80808080, 4'b0010);
    pushAcc(1'b0, 32'h0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h101, 32'h80);
    pushAcc(1'b1, 32'hFFFFFF80, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h101, 32'h0);
    pushAcc(1'b1, 32'h00008011, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);

    // No request: readData holds the last load.
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clock);
    checkOutput("readData_hold", readData, 32'h00008011);
    checkOutput("idle_stall", 32'(stall), 32'h0);
    @(posedge clock);
    #2;

    // Conflicting line evicts 0x100; reloading 0x100 misses again.
    pushRefill(32'h200);
    pushAcc(1'b1, 32'h55, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    pushRefill(32'h100);
    pushAcc(1'b1, 32'h00008011, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);

    // Word store miss: single write, no allocation; later load refills.
    pushWrite(32'h300, 32'hDEADBEEF, 4'hF);
    pushAcc(1'b0, 32'h0, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h300, 32'hDEADBEEF);
    pushRefill(32'h300);
    pushAcc(1'b1, 32'hDEADBEEF, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'h0);

    // Byte loads across offsets with and without sign extension.
    pushAcc(1'b1, 32'hFFFFFFAD, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h302, 32'h0);
    pushAcc(1'b1, 32'h0000007F, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h30F, 32'h0);
    pushAcc(1'b1, 32'h00000012, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h30E, 32'h0);

    // Reset in the middle of a refill, after the second ack.
    pushRefill(32'h400);
    void'(mem_q.pop_back());
    void'(mem_q.pop_back());
    memRead  = 1'b1;
    memWrite = 1'b0;
    word     = 1'b1;
    address  = 32'h400;
    n    = 0;
    acks = 0;
    while (acks < 2 && n < 40) begin
      @(negedge clock);
      n++;
      if (mem_req && mem_ack) acks++;
    end
    if (acks < 2) checkOutput("reset_test_acks", 32'(acks), 32'd2);
    @(posedge clock);
    #2;
    rst     = 1'b0;
    memRead = 1'b0;
    #1;
    checkOutput("midreset_mem_req", 32'(mem_req), 32'h0);
    checkOutput("midreset_stall", 32'(stall), 32'h0);
    checkOutput("midreset_mem_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clock);
    #2;
    rst = 1'b1;
    pushRefill(32'h400);
    pushAcc(1'b1, 32'hB0, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 32'h0);

    memRead  = 1'b0;
    memWrite = 1'b0;
    repeat (3) @(posedge clock);
    checkOutput("mem_queue_left", 32'(mem_q.size()), 32'h0);
    checkOutput("acc_queue_left", 32'(acc_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
